fetch_unit: RTL

Parametrised instruction-fetch front end for the RISC-V core. It replaces the bare PC register with a self-incrementing fetch PC that drives the instruction memory, accepts branch/jump redirects, and queues fetched {pc, instr} pairs in a small FIFO toward decode with a valid/ready handshake. Misaligned or out-of-range fetch addresses are reported as faults, and fetching stops until the next redirect.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: self-incrementing fetch PC, redirect handling,
// fault detection and a small {pc, instr, fault} FIFO toward decode.
module fetch_unit #(
   parameter int unsigned           XLEN         = 32,
   parameter int unsigned           IMEM_DEPTH   = 64,
   parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
   parameter int unsigned           BUF_DEPTH    = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_pc,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   input  logic [31:0]                   imem_rdata,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [XLEN-1:0]               out_pc,
   output logic [31:0]                   out_instr,
   output logic                          out_fault,
   output logic [XLEN-1:0]               fetch_pc,
   output logic                          halted
);

   localparam int unsigned     AW         = $clog2(IMEM_DEPTH);
   localparam int unsigned     PW         = $clog2(BUF_DEPTH);
   localparam int unsigned     CW         = PW + 1;
   localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(4 * IMEM_DEPTH);
   localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            fault;
   } entry_t;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HALT  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   entry_t          buf_q [BUF_DEPTH];

   logic            push_c;
   logic            pop_c;
   logic            fault_c;
   entry_t          entry_c;

   // Only [1:0] is checked; the range check is unsigned against the memory size in bytes.
   assign fault_c = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q >= IMEM_BYTES);

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      push_c      = 1'b0;
      pop_c       = 1'b0;
      entry_c     = '{pc: fetch_pc_q, instr: imem_rdata, fault: 1'b0};

      if (redirect_valid) begin
         // Redirect wins over push and pop; any same-cycle pop is discarded.
         state_d    = S_FETCH;
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         pop_c = (count_q != '0) && out_ready;
         if ((state_q == S_FETCH) && ((count_q < CW'(BUF_DEPTH)) || pop_c)) begin
            push_c = 1'b1;
            if (fault_c) begin
               entry_c.instr = NOP_INSTR;
               entry_c.fault = 1'b1;
               state_d       = S_HALT;
            end else begin
               fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
         end
         if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
         if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
         count_d = count_q + CW'(push_c) - CW'(pop_c);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_FETCH;
         fetch_pc_q <= RESET_VECTOR;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (push_c) buf_q[wr_ptr_q] <= entry_c;
      end
   end

   // Head entry is read straight from storage, so out_ready never reaches the outputs.
   assign out_valid = (count_q != '0);
   assign out_pc    = buf_q[rd_ptr_q].pc;
   assign out_instr = buf_q[rd_ptr_q].instr;
   assign out_fault = buf_q[rd_ptr_q].fault;
   assign fetch_pc  = fetch_pc_q;
   assign halted    = (state_q == S_HALT);
   assign imem_addr = fetch_pc_q[AW+1:2];

endmodule
